median_window_filter: RTL and testbench



---
 rtl/median_window_filter.sv | 149 ++++++++++++++
 tb/tb_median_window_filter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/median_window_filter.sv
// median_window_filter
//   Captures one WINDOW_SIZE x WINDOW_SIZE window of packed RGB pixels, one per
//   valid beat, keeps each channel in its own ascending sorted array (stable
//   insertion sort, one insert per cycle), and presents the per-channel median
//   with a one-cycle done pulse.
//
// Ports
//   Filter_CLK   in   clock, rising edge
//   Filter_RST   in   asynchronous active-high reset
//   Filter_EN    in   window enable from the controller, high for the transaction
//   Filter_DVLD  in   memory read data valid
//   Filter_DIN   in   memory read data {R, G, B}
//   Filter_DNE   out  done pulse, one cycle, coincident with new Filter_DOUT
//   Filter_DOUT  out  median pixel {R, G, B}, held until the next window result
//   Filter_BUSY  out  high in LOAD and EMIT
module median_window_filter #(
  parameter int unsigned DATA_WIDTH  = 24,
  parameter int unsigned WINDOW_SIZE = 3,
  parameter int unsigned CH_WIDTH    = 8
) (
  input  logic                  Filter_CLK,
  input  logic                  Filter_RST,
  input  logic                  Filter_EN,
  input  logic                  Filter_DVLD,
  input  logic [DATA_WIDTH-1:0] Filter_DIN,
  output logic                  Filter_DNE,
  output logic [DATA_WIDTH-1:0] Filter_DOUT,
  output logic                  Filter_BUSY
);

  localparam int unsigned N     = WINDOW_SIZE * WINDOW_SIZE;
  localparam int unsigned CntW  = $clog2(N + 1);
  localparam int unsigned Mid   = N / 2;
  localparam logic [CntW-1:0] NCnt = CntW'(N);

  localparam logic [1:0] StIdle    = 2'd0;
  localparam logic [1:0] StLoad    = 2'd1;
  localparam logic [1:0] StEmit    = 2'd2;
  localparam logic [1:0] StWaitLow = 2'd3;

  logic [1:0]            state_q, state_d;
  logic [CntW-1:0]       count_q, count_d;
  logic                  dne_q, dne_d;
  logic [DATA_WIDTH-1:0] dout_q, dout_d;
  logic                  slot_clr, slot_ld;

  // Channel index 0 = B, 1 = G, 2 = R (matches bit position in the pixel).
  logic [CH_WIDTH-1:0] slot_q   [3][N];
  logic [CH_WIDTH-1:0] slot_ins [3][N];

  // Stable insertion: the new value lands after every stored value <= it, so
  // slot i keeps its value, takes the new one, or takes its left neighbour.
  for (genvar c = 0; c < 3; c++) begin : g_ch
    logic [CH_WIDTH-1:0] pix;
    assign pix = Filter_DIN[c*CH_WIDTH +: CH_WIDTH];

    for (genvar i = 0; i < N; i++) begin : g_slot
      localparam logic [CntW-1:0] Idx = CntW'(i);
      logic                hold;
      logic                prev_le;
      logic [CH_WIDTH-1:0] prev_val;

      if (i == 0) begin : g_first
        assign prev_le  = 1'b1;
        assign prev_val = '0;
      end else begin : g_rest
        assign prev_le  = (slot_q[c][i-1] <= pix);
        assign prev_val = slot_q[c][i-1];
      end

      // Slots past the fill level stay put; occupied slots <= pix stay put.
      assign hold = (Idx > count_q) || ((Idx < count_q) && (slot_q[c][i] <= pix));
      assign slot_ins[c][i] = hold    ? slot_q[c][i] :
                              prev_le ? pix          : prev_val;
    end
  end

  always_comb begin
    state_d  = state_q;
    count_d  = count_q;
    dne_d    = 1'b0;
    dout_d   = dout_q;
    slot_clr = 1'b0;
    slot_ld  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (Filter_EN) begin
          count_d  = '0;
          slot_clr = 1'b1;
          state_d  = StLoad;
        end
      end
      StLoad: begin
        if (count_q == NCnt) begin
          state_d = StEmit;
        end else if (!Filter_EN) begin
          // Abort wins over a coincident valid beat.
          count_d = '0;
          state_d = StIdle;
        end else if (Filter_DVLD) begin
          slot_ld = 1'b1;
          count_d = count_q + 1'b1;
        end
      end
      StEmit: begin
        dout_d  = {slot_q[2][Mid], slot_q[1][Mid], slot_q[0][Mid]};
        dne_d   = 1'b1;
        state_d = StWaitLow;
      end
      StWaitLow: begin
        if (!Filter_EN) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Filter_CLK or posedge Filter_RST) begin
    if (Filter_RST) begin
      state_q <= StIdle;
      count_q <= '0;
      dne_q   <= 1'b0;
      dout_q  <= '0;
      for (int c = 0; c < 3; c++) begin
        for (int i = 0; i < N; i++) begin
          slot_q[c][i] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      dne_q   <= dne_d;
      dout_q  <= dout_d;
      if (slot_clr) begin
        for (int c = 0; c < 3; c++) begin
          for (int i = 0; i < N; i++) begin
            slot_q[c][i] <= '0;
          end
        end
      end else if (slot_ld) begin
        slot_q <= slot_ins;
      end
    end
  end

  assign Filter_DNE  = dne_q;
  assign Filter_DOUT = dout_q;
  assign Filter_BUSY = (state_q == StLoad) || (state_q == StEmit);

endmodule

// File: tb/tb_median_window_filter.sv
module tb_median_window_filter;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        dvld;
  logic [23:0] din;
  logic        dne;
  logic [23:0] dout;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  median_window_filter #(
    .DATA_WIDTH (24),
    .WINDOW_SIZE(3),
    .CH_WIDTH   (8)
  ) dut (
    .Filter_CLK (clk),
    .Filter_RST (rst),
    .Filter_EN  (en),
    .Filter_DVLD(dvld),
    .Filter_DIN (din),
    .Filter_DNE (dne),
    .Filter_DOUT(dout),
    .Filter_BUSY(busy)
  );

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Stimulus only: nine valid beats with `gap` idle cycles between beats.
  task automatic load_window(input logic [23:0] px[9], input int gap);
    for (int k = 0; k < 9; k++) begin
      dvld = 1'b1;
      din  = px[k];
      step();
      if (k < 8) begin
        for (int g = 0; g < gap; g++) begin
          dvld = 1'b0;
          din  = 24'hDEADBE;
          step();
        end
      end
    end
    dvld = 1'b0;
    din  = 24'h000000;
  endtask

  task automatic test_reset();
    rst  = 1'b1;
    en   = 1'b0;
    dvld = 1'b0;
    din  = 24'h0;
    #12;
    checks++;
    if (dne !== 1'b0 || dout !== 24'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL reset_values: dne=%b dout=%h busy=%b, want 0 000000 0", dne, dout, busy);
    end
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_single_window();
    logic [23:0] px[9];
    px = '{24'h0980FF, 24'h018000, 24'h0880FF, 24'h028000, 24'h0780FF,
           24'h038000, 24'h0680FF, 24'h048000, 24'h0580FF};
    // Beat coincident with EN in IDLE must be dropped.
    en   = 1'b1;
    dvld = 1'b1;
    din  = 24'hFFFFFF;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL single_busy_start: busy=%b want 1", busy);
    end
    load_window(px, 0);
    checks++;
    if (dne !== 1'b0) begin
      failures++;
      $display("FAIL single_dne_early1: dne=%b want 0", dne);
    end
    step();
    checks++;
    if (dne !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL single_emit_cycle: dne=%b busy=%b want 0 1", dne, busy);
    end
    step();
    checks++;
    if (dne !== 1'b1 || dout !== 24'h0580FF) begin
      failures++;
      $display("FAIL single_done: dne=%b dout=%h want 1 0580ff", dne, dout);
    end
    en = 1'b0;
    step();
    checks++;
    if (dne !== 1'b0 || busy !== 1'b0 || dout !== 24'h0580FF) begin
      failures++;
      $display("FAIL single_after: dne=%b busy=%b dout=%h want 0 0 0580ff", dne, busy, dout);
    end
  endtask

  task automatic test_stalls();
    logic [23:0] px[9];
    px = '{24'h0980FF, 24'h018000, 24'h0880FF, 24'h028000, 24'h0780FF,
           24'h038000, 24'h0680FF, 24'h048000, 24'h0580FF};
    en = 1'b1;
    step();
    load_window(px, 2);
    step();
    checks++;
    if (dne !== 1'b0) begin
      failures++;
      $display("FAIL stall_dne_early: dne=%b want 0", dne);
    end
    step();
    checks++;
    if (dne !== 1'b1 || dout !== 24'h0580FF) begin
      failures++;
      $display("FAIL stall_done: dne=%b dout=%h want 1 0580ff", dne, dout);
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_duplicates();
    logic [23:0] px[9];
    px = '{24'h123456, 24'h123456, 24'h123456, 24'hFFFFFF, 24'h123456,
           24'h123456, 24'h123456, 24'h123456, 24'h123456};
    en = 1'b1;
    step();
    load_window(px, 0);
    step();
    step();
    checks++;
    if (dne !== 1'b1 || dout !== 24'h123456) begin
      failures++;
      $display("FAIL dup_done: dne=%b dout=%h want 1 123456", dne, dout);
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_abort();
    logic [23:0] px[9];
    int          pulses;
    en = 1'b1;
    step();
    for (int k = 0; k < 5; k++) begin
      dvld = 1'b1;
      din  = 24'hAAAAAA;
      step();
    end
    // EN low with DVLD high: abort, beat not stored.
    en  = 1'b0;
    din = 24'h777777;
    step();
    dvld   = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (dne === 1'b1) pulses++;
      step();
    end
    checks++;
    if (pulses != 0 || busy !== 1'b0 || dout !== 24'h123456) begin
      failures++;
      $display("FAIL abort_quiet: pulses=%0d busy=%b dout=%h want 0 0 123456", pulses, busy, dout);
    end
    for (int k = 0; k < 9; k++) px[k] = 24'h010203;
    en = 1'b1;
    step();
    load_window(px, 0);
    checks++;
    if (dne !== 1'b0) begin
      failures++;
      $display("FAIL abort_next_early: dne=%b want 0", dne);
    end
    step();
    step();
    checks++;
    if (dne !== 1'b1 || dout !== 24'h010203) begin
      failures++;
      $display("FAIL abort_next_done: dne=%b dout=%h want 1 010203", dne, dout);
    end
  endtask

  // Continues from test_abort with EN still high in the DNE cycle.
  task automatic test_hold_enable();
    logic [23:0] px[9];
    int          pulses;
    pulses = 0;
    step();
    for (int k = 0; k < 20; k++) begin
      dvld = 1'b1;
      din  = 24'($urandom);
      if (dne === 1'b1) pulses++;
      step();
    end
    dvld = 1'b0;
    checks++;
    if (pulses != 0 || dout !== 24'h010203 || busy !== 1'b0) begin
      failures++;
      $display("FAIL hold_no_retrigger: pulses=%0d dout=%h busy=%b want 0 010203 0",
               pulses, dout, busy);
    end
    en = 1'b0;
    step();
    en = 1'b1;
    step();
    checks++;
    if (busy !== 1'b1) begin
      failures++;
      $display("FAIL hold_rearm: busy=%b want 1", busy);
    end
    px = '{24'h504009, 24'h104008, 24'h904007, 24'h304006, 24'h704005,
           24'h204004, 24'h804003, 24'h404002, 24'h604001};
    load_window(px, 1);
    step();
    step();
    checks++;
    if (dne !== 1'b1 || dout !== 24'h504005) begin
      failures++;
      $display("FAIL hold_new_window: dne=%b dout=%h want 1 504005", dne, dout);
    end
    en = 1'b0;
    step();
  endtask

  task automatic test_async_reset();
    logic [23:0] px[9];
    en = 1'b1;
    step();
    for (int k = 0; k < 4; k++) begin
      dvld = 1'b1;
      din  = 24'h999999;
      step();
    end
    dvld = 1'b0;
    #3 rst = 1'b1;
    #1;
    checks++;
    if (dne !== 1'b0 || dout !== 24'h0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL rst_mid_load: dne=%b dout=%h busy=%b want 0 000000 0", dne, dout, busy);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
    for (int k = 0; k < 9; k++) px[k] = 24'h0A0B0C;
    en = 1'b1;
    step();
    load_window(px, 0);
    step();
    step();
    checks++;
    if (dne !== 1'b1 || dout !== 24'h0A0B0C) begin
      failures++;
      $display("FAIL rst_after_window: dne=%b dout=%h want 1 0a0b0c", dne, dout);
    end
    // Reset during the DNE pulse drops it without waiting for an edge.
    #2 rst = 1'b1;
    #1;
    checks++;
    if (dne !== 1'b0 || dout !== 24'h0) begin
      failures++;
      $display("FAIL rst_during_dne: dne=%b dout=%h want 0 000000", dne, dout);
    end
    en = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_single_window();
    test_stalls();
    test_duplicates();
    test_abort();
    test_hold_enable();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
